// File: rtl/mad_scoreboard_pkg.sv
//------------------------------------------------------------------------------
// mad_scoreboard_pkg : shared types and helpers for the MAD result scoreboard
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mad_scoreboard_pkg;

  localparam int CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_DONE      = 2'd2,
    ST_FAIL_HALT = 2'd3
  } sb_state_e;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mad_result_scoreboard_if.sv
//------------------------------------------------------------------------------
// mad_result_scoreboard_if : MAD snoop signals plus scoreboard verdict outputs
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mad_result_scoreboard_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8
);
  logic                    IE;
  logic                    IREADY;
  logic [DATA_WIDTH-1:0]   A;
  logic [DATA_WIDTH-1:0]   B;
  logic [DATA_WIDTH-1:0]   C;
  logic                    OE;
  logic [DATA_WIDTH-1:0]   O;
  logic                    EOT;
  logic [15:0]             PASS_CNT;
  logic [15:0]             FAIL_CNT;
  logic [$clog2(DEPTH):0]  PENDING;
  logic                    OVERFLOW;
  logic                    UNDERFLOW;
  logic                    TIMEOUT;
  logic                    ERROR;
  logic                    DONE;

  modport master (
    output IE, IREADY, A, B, C, OE, O, EOT,
    input  PASS_CNT, FAIL_CNT, PENDING, OVERFLOW, UNDERFLOW, TIMEOUT, ERROR, DONE
  );

  modport slave (
    input  IE, IREADY, A, B, C, OE, O, EOT,
    output PASS_CNT, FAIL_CNT, PENDING, OVERFLOW, UNDERFLOW, TIMEOUT, ERROR, DONE
  );
endinterface

`default_nettype wire

// File: rtl/mad_expect_fifo.sv
//------------------------------------------------------------------------------
// mad_expect_fifo : in-order queue of expected MAD results
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mad_expect_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  push_data,
  input  logic                   pop,
  output logic [DATA_WIDTH-1:0]  pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  // A full queue still accepts a push when a pop frees the head slot this cycle.
  assign w_do_push = push & (~full | w_do_pop);
  assign pop_data  = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: rtl/mad_result_scoreboard.sv
//------------------------------------------------------------------------------
// mad_result_scoreboard : golden A*B+C checker for MAD results, in-order queue.
// Optional head-age timeout enabled by MAD_SCOREBOARD_TIMEOUT_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mad_result_scoreboard
  import mad_scoreboard_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 8,
  parameter int MAX_LATENCY = 16
) (
  input logic                    CLK,
  input logic                    RST,
  mad_result_scoreboard_if.slave bus
);
  localparam int PW = $clog2(DEPTH) + 1;

  sb_state_e             r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] w_expected, w_head, w_ref;
  logic [PW-1:0]         w_count;
  logic                  w_full, w_empty;
  logic                  w_push, w_bypass, w_fifo_push, w_fifo_pop, w_cmp, w_match;
  logic                  w_underflow_evt, w_overflow_evt, w_timeout_evt, w_error_evt;
  logic [CNT_WIDTH-1:0]  r_pass_cnt, r_fail_cnt;
  logic                  r_mismatch, r_overflow, r_underflow, r_timeout;

  assign w_push          = bus.IE & bus.IREADY;
  assign w_expected      = bus.A * bus.B + bus.C;
  // Result arriving alongside its own operands on an empty queue is checked directly.
  assign w_bypass        = w_empty & bus.OE & w_push;
  assign w_fifo_push     = w_push & ~w_bypass;
  assign w_fifo_pop      = bus.OE & ~w_empty;
  assign w_cmp           = w_fifo_pop | w_bypass;
  assign w_ref           = w_empty ? w_expected : w_head;
  assign w_match         = (bus.O == w_ref);
  assign w_underflow_evt = bus.OE & w_empty & ~w_push;
  assign w_overflow_evt  = w_push & w_full & ~bus.OE;

  mad_expect_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (w_fifo_push),
    .push_data (w_expected),
    .pop       (w_fifo_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

`ifdef MAD_SCOREBOARD_TIMEOUT_EN
  localparam int AGE_W = $clog2(MAX_LATENCY + 1);
  logic [AGE_W-1:0] r_age;

  always_ff @(posedge CLK) begin
    if (RST)
      r_age <= '0;
    else if (w_fifo_pop | (w_fifo_push & w_empty))
      r_age <= '0;
    else if ((w_count != '0) && (r_age != AGE_W'(MAX_LATENCY)))
      r_age <= r_age + AGE_W'(1);
  end

  assign w_timeout_evt = (w_count != '0) & (r_age == AGE_W'(MAX_LATENCY));
`else
  logic w_unused_max_latency;
  assign w_unused_max_latency = (MAX_LATENCY != 0);
  assign w_timeout_evt        = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_mismatch  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_timeout   <= 1'b0;
      r_state     <= ST_RUN;
    end else begin
      if (w_cmp && w_match)  r_pass_cnt <= sat_inc(r_pass_cnt);
      if (w_cmp && !w_match) begin
        r_fail_cnt <= sat_inc(r_fail_cnt);
        r_mismatch <= 1'b1;
      end
      if (w_overflow_evt)  r_overflow  <= 1'b1;
      if (w_underflow_evt) r_underflow <= 1'b1;
      if (w_timeout_evt)   r_timeout   <= 1'b1;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_error_evt = (w_cmp & ~w_match) | w_overflow_evt | w_underflow_evt | w_timeout_evt |
                  r_mismatch | r_overflow | r_underflow | r_timeout;
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_error_evt)  w_state_nxt = ST_FAIL_HALT;
        else if (bus.EOT) w_state_nxt = (w_count == '0) ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_error_evt)           w_state_nxt = ST_FAIL_HALT;
        else if (w_count == '0)    w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  assign bus.PASS_CNT  = r_pass_cnt;
  assign bus.FAIL_CNT  = r_fail_cnt;
  assign bus.PENDING   = w_count;
  assign bus.OVERFLOW  = r_overflow;
  assign bus.UNDERFLOW = r_underflow;
  assign bus.TIMEOUT   = r_timeout;
  assign bus.ERROR     = r_mismatch | r_overflow | r_underflow | r_timeout;
  assign bus.DONE      = (r_state == ST_DONE) | (r_state == ST_FAIL_HALT);
endmodule

`default_nettype wire

// File: tb/tb_mad_result_scoreboard.sv
//------------------------------------------------------------------------------
// tb_mad_result_scoreboard : directed checks of the MAD result scoreboard
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mad_result_scoreboard;
  logic CLK;
  logic RST;
  int   n_tests;
  int   n_fail;

  mad_result_scoreboard_if #(.DATA_WIDTH(64), .DEPTH(8)) bus ();

  mad_result_scoreboard #(.DATA_WIDTH(64), .DEPTH(8), .MAX_LATENCY(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.IE  = 1'b0;
    bus.OE  = 1'b0;
    bus.EOT = 1'b0;
    bus.A   = '0;
    bus.B   = '0;
    bus.C   = '0;
    bus.O   = '0;
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
  endtask

  task automatic drive_push(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    bus.IE = 1'b1;
    bus.A  = a;
    bus.B  = b;
    bus.C  = c;
  endtask

  task automatic drive_pop(input logic [63:0] o);
    bus.OE = 1'b1;
    bus.O  = o;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    RST        = 1'b1;
    bus.IREADY = 1'b1;
    idle();
    cyc();
    do_reset();

    // Reset state
    check("rst_pass", bus.PASS_CNT, 0);
    check("rst_fail", bus.FAIL_CNT, 0);
    check("rst_pending", bus.PENDING, 0);
    check("rst_error", bus.ERROR, 0);
    check("rst_done", bus.DONE, 0);

    // Three correct results, EOT while entries pending, then drain
    drive_push(3, 4, 5); cyc();
    drive_push(5, 6, 7); cyc();
    drive_push(7, 8, 9); cyc();
    bus.IE = 1'b0;
    check("t1_pending3", bus.PENDING, 3);
    bus.EOT = 1'b1; drive_pop(17); cyc();
    bus.EOT = 1'b0; drive_pop(37); cyc();
    drive_pop(65); cyc();
    bus.OE = 1'b0;
    check("t1_drain_not_done", bus.DONE, 0);
    cyc();
    check("t1_pass", bus.PASS_CNT, 3);
    check("t1_fail", bus.FAIL_CNT, 0);
    check("t1_error", bus.ERROR, 0);
    check("t1_pending0", bus.PENDING, 0);
    check("t1_done", bus.DONE, 1);

    // Mismatch: 11*12+13 = 145, MAD returns 144
    do_reset();
    drive_push(11, 12, 13); cyc();
    bus.IE = 1'b0;
    drive_pop(144); cyc();
    bus.OE = 1'b0;
    check("t2_fail", bus.FAIL_CNT, 1);
    check("t2_pass", bus.PASS_CNT, 0);
    check("t2_error", bus.ERROR, 1);
    cyc();
    check("t2_done", bus.DONE, 1);

    // Bypass: 19*20+21 = 401 pushed and returned in the same cycle
    do_reset();
    drive_push(19, 20, 21); drive_pop(401); cyc();
    idle();
    check("t3_pass", bus.PASS_CNT, 1);
    check("t3_pending", bus.PENDING, 0);
    check("t3_error", bus.ERROR, 0);

    // Overflow: 9 pushes of (i, i+1, i+2), 9th dropped
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      drive_push(i, i + 1, i + 2); cyc();
      if (i == 8) begin
        check("t4_pending8", bus.PENDING, 8);
        check("t4_no_ovf_yet", bus.OVERFLOW, 0);
      end
    end
    bus.IE = 1'b0;
    check("t4_overflow", bus.OVERFLOW, 1);
    check("t4_pending_full", bus.PENDING, 8);
    check("t4_ovf_error", bus.ERROR, 1);
    // Full queue: pop i=1 (1*2+3=5) and push 20*2+3=43 together
    drive_pop(5); drive_push(20, 2, 3); cyc();
    bus.IE = 1'b0;
    check("t4_full_pushpop_pending", bus.PENDING, 8);
    check("t4_full_pushpop_pass", bus.PASS_CNT, 1);
    for (int i = 2; i <= 8; i++) begin
      drive_pop(i * (i + 1) + i + 2); cyc();
    end
    drive_pop(43); cyc();
    bus.OE = 1'b0;
    check("t4_pass", bus.PASS_CNT, 9);
    check("t4_fail", bus.FAIL_CNT, 0);
    check("t4_pending_empty", bus.PENDING, 0);

    // Underflow, then reset with traffic ignored during the reset cycle
    do_reset();
    drive_pop(0); cyc();
    bus.OE = 1'b0;
    check("t5_underflow", bus.UNDERFLOW, 1);
    check("t5_pass", bus.PASS_CNT, 0);
    check("t5_fail", bus.FAIL_CNT, 0);
    check("t5_error", bus.ERROR, 1);
    cyc();
    check("t5_done", bus.DONE, 1);
    RST = 1'b1; drive_push(2, 3, 4); drive_pop(10); cyc();
    RST = 1'b0; idle();
    check("t5_rst_underflow", bus.UNDERFLOW, 0);
    check("t5_rst_error", bus.ERROR, 0);
    check("t5_rst_done", bus.DONE, 0);
    check("t5_rst_pending", bus.PENDING, 0);
    check("t5_rst_pass", bus.PASS_CNT, 0);

    // Head entry withheld for 20 cycles
    drive_push(1, 1, 1); cyc();
    bus.IE = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
`ifdef MAD_SCOREBOARD_TIMEOUT_EN
    check("t6_timeout", bus.TIMEOUT, 1);
    check("t6_timeout_error", bus.ERROR, 1);
`else
    check("t6_timeout", bus.TIMEOUT, 0);
    check("t6_timeout_error", bus.ERROR, 0);
`endif
    check("t6_pending", bus.PENDING, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
